// File: rtl/vectadd_pkg.sv
// Shared definitions for the vectadd_hw_seq block.
// Holds the control FSM state encoding and the bit positions of the
// software command word (to_hw_sig) and the status word (from_hw_sig).
package vectadd_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Command word bit indices
  localparam int unsigned CMD_START = 0;
  localparam int unsigned CMD_CLEAR = 1;

  // Status word bit indices
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;

  localparam int unsigned CMD_W  = 2;
  localparam int unsigned STAT_W = 2;

endpackage : vectadd_pkg

// File: rtl/vectadd_adder.sv
// Registered element adder, latency 1.
// Default build: modulo 2^DATA_W addition (carry discarded).
// With VECTADD_SAT_EN defined: signed two's-complement saturating addition.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   en_i       - capture enable (operands valid this cycle)
//   a_i, b_i   - operands
//   sum_o      - registered result
module vectadd_adder #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] sum_d;
  logic [DATA_W-1:0] sum_q;

`ifdef VECTADD_SAT_EN
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0] sum_ext;

  // Sign-extend by one bit; the top two bits disagree exactly on overflow.
  always_comb begin
    sum_ext = {a_i[DATA_W-1], a_i} + {b_i[DATA_W-1], b_i};
    sum_d   = sum_ext[DATA_W-1:0];
    if (sum_ext[DATA_W] != sum_ext[DATA_W-1]) begin
      sum_d = sum_ext[DATA_W] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  always_comb begin
    sum_d = a_i + b_i;
  end
`endif

  // Result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule : vectadd_adder

// File: rtl/vectadd_hw_seq.sv
// Sequential vector adder: C[i] = A[i] + B[i] for i = 0..VEC_LEN-1.
// Reads A and B through a shared read port (1-cycle read latency), adds in
// a registered adder and writes C two cycles after each read strobe.
// Optional feature macro: VECTADD_SAT_EN (signed saturating add).
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   to_hw_sig[1:0]      - command: bit0 start (rising edge), bit1 clear
//   from_hw_sig[1:0]    - status: bit0 busy, bit1 done (sticky)
//   rd_addr, rd_en      - operand memory read address / strobe
//   a_rdata, b_rdata    - operand read data, valid one cycle after rd_en
//   c_addr, c_wdata     - result write address / data
//   c_we                - result write strobe
module vectadd_hw_seq
  import vectadd_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned VEC_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        to_hw_sig,
  output logic [1:0]        from_hw_sig,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] a_rdata,
  input  logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wdata,
  output logic              c_we
);

  // Index of the final element; fits ADDR_W even when VEC_LEN = 2^ADDR_W.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VEC_LEN - 1);

  state_e              state_q, state_d;
  logic                start_q;
  logic                start_edge;
  logic                clear;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rvalid_q;
  logic [ADDR_W-1:0]   raddr_q;
  logic                c_we_q;
  logic [ADDR_W-1:0]   c_addr_q;
  logic [STAT_W-1:0]   status_q, status_d;

  assign clear      = to_hw_sig[CMD_CLEAR];
  assign start_edge = to_hw_sig[CMD_START] & ~start_q;

  // Start edge detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
    end else begin
      start_q <= to_hw_sig[CMD_START];
    end
  end

  // Control FSM: state, read issue and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      status_q  <= status_d;
    end
  end

  // Next-state, next read strobe/address and next status
  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    status_d  = '0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          state_d   = ST_RUN;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      ST_RUN: begin
        // rd_addr_q is the index being read this cycle; hold it after the last.
        if (rd_addr_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (c_we_q && (c_addr_q == LAST_IDX)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear overrides everything, including a simultaneous start edge.
    if (clear) begin
      state_d = ST_IDLE;
      rd_en_d = 1'b0;
    end

    status_d[STAT_BUSY] = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    status_d[STAT_DONE] = (state_d == ST_DONE);
  end

  // Write pipeline: read-data stage then adder stage; clear kills in-flight work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      raddr_q  <= '0;
      c_we_q   <= 1'b0;
      c_addr_q <= '0;
    end else begin
      rvalid_q <= rd_en_q & ~clear;
      c_we_q   <= rvalid_q & ~clear;
      if (rd_en_q) begin
        raddr_q <= rd_addr_q;
      end
      if (rvalid_q) begin
        c_addr_q <= raddr_q;
      end
    end
  end

  vectadd_adder #(
    .DATA_W (DATA_W)
  ) u_adder (
    .clk   (clk),
    .rst   (reset),
    .en_i  (rvalid_q),
    .a_i   (a_rdata),
    .b_i   (b_rdata),
    .sum_o (c_wdata)
  );

  assign from_hw_sig = status_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign c_we        = c_we_q;
  assign c_addr      = c_addr_q;

endmodule : vectadd_hw_seq

// File: tb/tb_vectadd_hw_seq.sv
// Testbench for vectadd_hw_seq: two instances (VEC_LEN=4 and VEC_LEN=1,
// both ADDR_W=2) share the command input and the operand memories.
module tb_vectadd_hw_seq;

  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  to_hw_sig;

  logic [1:0]  from_hw_sig [NI];
  logic [1:0]  rd_addr     [NI];
  logic        rd_en       [NI];
  logic [31:0] a_rdata     [NI];
  logic [31:0] b_rdata     [NI];
  logic [1:0]  c_addr      [NI];
  logic [31:0] c_wdata     [NI];
  logic        c_we        [NI];

  logic [31:0] mem_a [4];
  logic [31:0] mem_b [4];

  int n_vec  = 0;
  int n_miss = 0;

  // Activity statistics, only ever written by the monitor
  int          rdcnt   [NI];
  int          busycnt [NI];
  int          wcnt    [NI];
  logic [1:0]  wlog_a  [NI][256];
  logic [31:0] wlog_d  [NI][256];

  always #5 clk = ~clk;

  vectadd_hw_seq #(.DATA_W(32), .ADDR_W(2), .VEC_LEN(4)) u_dut4 (
    .clk(clk), .reset(reset), .to_hw_sig(to_hw_sig), .from_hw_sig(from_hw_sig[0]),
    .rd_addr(rd_addr[0]), .rd_en(rd_en[0]), .a_rdata(a_rdata[0]), .b_rdata(b_rdata[0]),
    .c_addr(c_addr[0]), .c_wdata(c_wdata[0]), .c_we(c_we[0])
  );

  vectadd_hw_seq #(.DATA_W(32), .ADDR_W(2), .VEC_LEN(1)) u_dut1 (
    .clk(clk), .reset(reset), .to_hw_sig(to_hw_sig), .from_hw_sig(from_hw_sig[1]),
    .rd_addr(rd_addr[1]), .rd_en(rd_en[1]), .a_rdata(a_rdata[1]), .b_rdata(b_rdata[1]),
    .c_addr(c_addr[1]), .c_wdata(c_wdata[1]), .c_we(c_we[1])
  );

  function automatic int vlen(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Synchronous-read operand memories, one read port per instance
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rd_en[k]) begin
        a_rdata[k] <= mem_a[rd_addr[k]];
        b_rdata[k] <= mem_b[rd_addr[k]];
      end
    end
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      rdcnt[k] = 0; busycnt[k] = 0; wcnt[k] = 0;
    end
  end

  // Monitor, sampling mid-cycle
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rd_en[k]) rdcnt[k]++;
      if (from_hw_sig[k][0]) busycnt[k]++;
      if (c_we[k]) begin
        if (wcnt[k] < 256) begin
          wlog_a[k][wcnt[k]] = c_addr[k];
          wlog_d[k][wcnt[k]] = c_wdata[k];
        end
        wcnt[k]++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference element sum
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
`ifdef VECTADD_SAT_EN
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
`else
    longint unsigned s;
    s = longint'(a) + longint'(b);
    return s[31:0];
`endif
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start, wait for both instances to report done, then check the run.
  task automatic run_and_check(input string tag);
    int rb [NI];
    int bb [NI];
    int wb [NI];
    int guard;
    for (int k = 0; k < NI; k++) begin
      rb[k] = rdcnt[k]; bb[k] = busycnt[k]; wb[k] = wcnt[k];
    end
    to_hw_sig = 2'b01;
    tick();
    to_hw_sig = 2'b00;
    check({tag, "_first_rden"}, 64'(rd_en[0]), 64'd1);
    check({tag, "_first_addr"}, 64'(rd_addr[0]), 64'd0);
    guard = 0;
    while (!(from_hw_sig[0][1] && from_hw_sig[1][1]) && guard < 60) begin
      tick();
      guard++;
    end
    check({tag, "_timeout"}, 64'(guard < 60), 64'd1);
    tick(2);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_i%0d_wcnt", tag, k), 64'(wcnt[k] - wb[k]), 64'(vlen(k)));
      check($sformatf("%s_i%0d_rdcnt", tag, k), 64'(rdcnt[k] - rb[k]), 64'(vlen(k)));
      check($sformatf("%s_i%0d_busy", tag, k), 64'(busycnt[k] - bb[k]), 64'(vlen(k) + 2));
      check($sformatf("%s_i%0d_status", tag, k), 64'(from_hw_sig[k]), 64'd2);
      check($sformatf("%s_i%0d_nowrap", tag, k), 64'(rd_addr[k]), 64'(vlen(k) - 1));
      for (int i = 0; i < vlen(k) && (wb[k] + i) < 256; i++) begin
        check($sformatf("%s_i%0d_addr%0d", tag, k, i), 64'(wlog_a[k][wb[k] + i]), 64'(i));
        check($sformatf("%s_i%0d_data%0d", tag, k, i), 64'(wlog_d[k][wb[k] + i]),
              64'(ref_add(mem_a[i], mem_b[i])));
      end
    end
  endtask

  initial begin
    int rb [NI];
    int wb [NI];
    to_hw_sig = 2'b00;
    reset     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 32'(i + 1);
      mem_b[i] = 32'((i + 1) * 10);
    end
    tick(3);

    // Reset values
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_i%0d_status", k), 64'(from_hw_sig[k]), 64'd0);
      check($sformatf("rst_i%0d_rden", k), 64'(rd_en[k]), 64'd0);
      check($sformatf("rst_i%0d_cwe", k), 64'(c_we[k]), 64'd0);
      check($sformatf("rst_i%0d_rdaddr", k), 64'(rd_addr[k]), 64'd0);
      check($sformatf("rst_i%0d_caddr", k), 64'(c_addr[k]), 64'd0);
      check($sformatf("rst_i%0d_cwdata", k), 64'(c_wdata[k]), 64'd0);
    end
    reset = 1'b0;
    tick(2);

    // Directed A={1,2,3,4}, B={10,20,30,40}
    run_and_check("basic");

    // Randomized runs, first two seeded with overflow corners
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) begin
        mem_a[i] = $urandom();
        mem_b[i] = $urandom();
      end
      if (r == 0) begin mem_a[0] = 32'h7FFF_FFFF; mem_b[0] = 32'h0000_0001; end
      if (r == 1) begin mem_a[0] = 32'h8000_0000; mem_b[0] = 32'hFFFF_FFFF; end
      run_and_check($sformatf("rnd%0d", r));
    end

    // Start held high for 20 cycles from DONE: exactly one run
    for (int k = 0; k < NI; k++) begin rb[k] = rdcnt[k]; wb[k] = wcnt[k]; end
    to_hw_sig = 2'b01;
    tick(20);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("hold_i%0d_rdcnt", k), 64'(rdcnt[k] - rb[k]), 64'(vlen(k)));
      check($sformatf("hold_i%0d_wcnt", k), 64'(wcnt[k] - wb[k]), 64'(vlen(k)));
      check($sformatf("hold_i%0d_done", k), 64'(from_hw_sig[k]), 64'd2);
    end
    to_hw_sig = 2'b00;
    tick(2);

    // Start and clear rising together: clear wins
    for (int k = 0; k < NI; k++) rb[k] = rdcnt[k];
    to_hw_sig = 2'b11;
    tick();
    to_hw_sig = 2'b00;
    tick(10);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("sc_i%0d_rdcnt", k), 64'(rdcnt[k] - rb[k]), 64'd0);
      check($sformatf("sc_i%0d_status", k), 64'(from_hw_sig[k]), 64'd0);
    end

    // Clear on the third RUN cycle
    to_hw_sig = 2'b01;
    tick();
    to_hw_sig = 2'b00;
    tick(2);
    to_hw_sig = 2'b10;
    tick();
    for (int k = 0; k < NI; k++) wb[k] = wcnt[k];
    tick(3);
    to_hw_sig = 2'b00;
    tick(5);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("clr_i%0d_wr_le1", k), 64'((wcnt[k] - wb[k]) <= 1), 64'd1);
      check($sformatf("clr_i%0d_cwe", k), 64'(c_we[k]), 64'd0);
      check($sformatf("clr_i%0d_status", k), 64'(from_hw_sig[k]), 64'd0);
    end

    // Recovery after clear
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = $urandom();
      mem_b[i] = $urandom();
    end
    run_and_check("postclr");

    // Reset mid-run aborts at once; no run without a new start edge
    to_hw_sig = 2'b01;
    tick();
    to_hw_sig = 2'b00;
    tick();
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("mrst_i%0d_rden", k), 64'(rd_en[k]), 64'd0);
      check($sformatf("mrst_i%0d_cwe", k), 64'(c_we[k]), 64'd0);
      check($sformatf("mrst_i%0d_status", k), 64'(from_hw_sig[k]), 64'd0);
    end
    tick(2);
    for (int k = 0; k < NI; k++) begin rb[k] = rdcnt[k]; wb[k] = wcnt[k]; end
    reset = 1'b0;
    tick(10);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("mrst_i%0d_norun", k), 64'(rdcnt[k] - rb[k]), 64'd0);
      check($sformatf("mrst_i%0d_nowr", k), 64'(wcnt[k] - wb[k]), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_vectadd_hw_seq
